if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch/decode boundary register with an elastic instruction queue. It sits between IF and ID in place of a single-entry pipeline latch. While ID is stalled it absorbs up to DEPTH fetched instructions, so IF can keep fetching. A branch flush clears every buffered instruction in one cycle. When no instruction is available it emits a zero bubble (pc 0, inst 0), as the single-entry latch did.

## Interface
- ADDR_W, 32, width of instruction address
- INST_W, 32, width of instruction word
- DEPTH, 4, number of buffer entries; power of two, at least 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  IF presents an instruction this cycle
- if_pc  in  ADDR_W  address of the presented instruction
- if_inst  in  INST_W  presented instruction word
- if_ready  out  1  queue accepts an instruction this cycle; combinational, equals (count != DEPTH)
- br  in  1  branch flush from EX; discards everything not yet delivered
- stall  in  5  pipeline stall vector; only bit 1 (ID stalled) is used
- id_valid  out  1  registered; the id_pc and id_inst outputs hold a real instruction
- id_pc  out  ADDR_W  registered instruction address to ID
- id_inst  out  INST_W  registered instruction word to ID
- count  out  CNT_W  registered number of entries in the buffer, excluding the output register

## Operation
- Storage: a circular buffer of DEPTH entries, each holding {pc, inst}. Read pointer rp and write pointer wp are each log2(DEPTH) bits wide and wrap modulo DEPTH. count has range 0..DEPTH.
- Push condition: push = if_valid & if_ready & ~br & ~bypass.
- The priority order below is evaluated once per rising edge.
  1. rst: rp = wp = 0, count = 0, id_valid = 0, id_pc = 0, id_inst = 0.
  2. br, regardless of stall[1]: rp = wp = 0 and count = 0. The output register goes to bubble (id_valid = 0, pc 0, inst 0). The IF input in the same cycle is dropped.
  3. stall[1] = 1: the output register holds. If push, write the input at wp, wp += 1, count += 1.
  4. stall[1] = 0 and count > 0: pop the entry at rp into the output register with id_valid = 1, and rp += 1. If push is also true, the input is written at wp in the same edge. count changes by push minus 1.
  5. stall[1] = 0, count = 0, if_valid = 1 (bypass): the input loads directly into the output register with id_valid = 1. Nothing is written to the buffer.
  6. stall[1] = 0, count = 0, if_valid = 0: the output register loads the bubble (id_valid = 0, pc 0, inst 0).
- Instructions reach ID in strict program order, with no duplication and no loss except on br.
- When full, if_ready = 0 even if a pop occurs in the same cycle. IF must hold its pc/inst until it sees if_ready = 1.
- Write and pop at the same index in the same cycle cannot happen: that would require count equal to 0 or DEPTH, and pop needs count > 0 while push needs count < DEPTH.

## Timing
- Latency with the buffer empty and no stall: IF input at edge n appears on the id outputs after edge n+1 (1 cycle, identical to the single-entry latch).
- Latency with a backlog of k entries and no stall: k+1 cycles. Throughput is 1 instruction per cycle.
- if_ready is combinational from the registered count only. There is no path from stall, br, or if_valid to if_ready.
- A stall asserted for N cycles accepts at most DEPTH instructions. After that, if_ready stays low until the first unstalled edge.
- Flush takes 1 edge. The cycle after br: count = 0, id_valid = 0, if_ready = 1.
- A rst or br that arrives mid-drain discards the remaining entries. Pointer wrap-around needs no special case.

## Test plan
- Reset: hold rst 2 cycles with if_valid = 1 → id_valid = 0, id_pc = 0, id_inst = 0, count = 0, if_ready = 1; no instruction accepted.
- Streaming: stall = 0, if_valid = 1 with pc 0x00, 0x04, 0x08, … on consecutive cycles → each pc appears on id_pc exactly 1 cycle later, count stays 0 throughout.
- Fill and drain (DEPTH = 4): set stall[1] = 1 while id holds 0x00, push pc 0x04..0x10 → count reaches 4, then if_ready = 0 and 0x14 is held. Release the stall → id_pc shows 0x04, 0x08, 0x0C, 0x10, 0x14 on consecutive cycles.
- Simultaneous push/pop at count = 2, unstalled, if_valid = 1 → count stays 2 and order is preserved. Run 3×DEPTH such cycles so rp and wp wrap → no corruption.
- Flush while stalled with count = 3 and br = 1, if_valid = 1 → next cycle count = 0, id_valid = 0, id_pc = 0. The flush-cycle instruction never appears, and the next fetched pc arrives 1 cycle after it is presented.
- Stall with no backlog: stall[1] = 1 with count = 0 and if_valid = 0 for 5 cycles → the outputs keep the last instruction unchanged and count = 0.

Source files
------------

// File: rtl/if_id_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_id_queue                                                       |
// | Purpose : IF/ID boundary register backed by an elastic instruction queue    |
// |           that absorbs fetches while ID stalls and clears on branch flush.  |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              br,
  input  logic [4:0]        stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);

  localparam int              PTR_W        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);

  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [PTR_W-1:0]  r_rp;
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_count;
  logic              r_id_valid;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;

  logic w_stall_id;
  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_unused_stall;

  assign w_stall_id     = stall[1];
  assign w_unused_stall = ^{stall[4:2], stall[0]};
  assign w_empty        = (r_count == '0);

  // Ready depends on the registered occupancy only, so IF sees no path from stall or br.
  assign if_ready = (r_count != c_full_count);
  assign w_bypass = ~w_stall_id & w_empty & if_valid;
  assign w_push   = if_valid & if_ready & ~br & ~w_bypass;
  assign w_pop    = ~w_stall_id & ~w_empty & ~br;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wp]   <= if_pc;
      r_mem_inst[r_wp] <= if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || br) begin
      r_rp       <= '0;
      r_wp       <= '0;
      r_count    <= '0;
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase

      if (w_stall_id) begin
        r_id_valid <= r_id_valid;
      end else if (w_pop) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= r_mem_pc[r_rp];
        r_id_inst  <= r_mem_inst[r_rp];
        r_rp       <= r_rp + c_ptr_one;
      end else if (w_bypass) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= if_pc;
        r_id_inst  <= if_inst;
      end else begin
        r_id_valid <= 1'b0;
        r_id_pc    <= '0;
        r_id_inst  <= '0;
      end
    end
  end

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_if_id_queue                                                    |
// | Purpose : self-checking bench for if_id_queue (vector table + queue model)  |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              br;
  logic [4:0]        stall;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  count;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: accepted-but-undelivered pcs plus the expected output register.
  logic [31:0] sb_q[$];
  logic        m_v  = 1'b0;
  logic [31:0] m_pc = '0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic        exp_v;
    logic [31:0] exp_pc;
    int          exp_cnt;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[12];

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .br       (br),
    .stall    (stall),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic st,
                              input logic ev, input logic [31:0] epc, input int ecnt,
                              input logic erdy);
    vec_t t;
    t.v = v; t.pc = pc; t.st = st;
    t.exp_v = ev; t.exp_pc = epc; t.exp_cnt = ecnt; t.exp_rdy = erdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model with pre-edge state, sample #1 after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                     input logic b, input logic s, output logic acc);
    logic m_ready;
    rst      = r;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    br       = b;
    stall    = {3'($urandom), s, 1'($urandom)};
    m_ready  = (sb_q.size() != DEPTH);
    acc      = v & m_ready & ~b & ~r;
    if (r || b) begin
      sb_q.delete();
      m_v  = 1'b0;
      m_pc = '0;
    end else if (s) begin
      if (v && m_ready) sb_q.push_back(pc);
    end else if (sb_q.size() > 0) begin
      m_pc = sb_q.pop_front();
      m_v  = 1'b1;
      if (v && m_ready) sb_q.push_back(pc);
    end else if (v) begin
      m_pc = pc;
      m_v  = 1'b1;
    end else begin
      m_v  = 1'b0;
      m_pc = '0;
    end
    @(posedge clk);
    #1;
    chk("id_valid", 64'(id_valid), 64'(m_v));
    chk("id_pc", 64'(id_pc), 64'(m_pc));
    chk("id_inst", 64'(id_inst), m_v ? 64'(inst_of(m_pc)) : 64'd0);
    chk("count", 64'(count), 64'(sb_q.size()));
    chk("if_ready", 64'(if_ready), 64'(sb_q.size() != DEPTH));
  endtask

  initial begin
    logic        acc;
    logic [31:0] rpc;
    logic        rv, rb, rs, rr;

    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; br = 1'b0; stall = '0;

    // Reset held with a valid fetch: nothing is accepted, outputs are zero.
    cyc(1, 1, 32'h40, 0, 0, acc);
    cyc(1, 1, 32'h40, 0, 0, acc);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);

    // Streaming: each pc appears one cycle later with no backlog.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 32'(i * 4), 0, 0, acc);
      chk("stream_pc", 64'(id_pc), 64'(i * 4));
      chk("stream_count", 64'(count), 64'd0);
    end
    cyc(0, 0, 32'h0, 0, 0, acc);

    // Fill to DEPTH under stall, hold 0x14 while full, then drain in order.
    tbl[0]  = mk(1, 32'h00, 0, 1, 32'h00, 0, 1);
    tbl[1]  = mk(1, 32'h04, 1, 1, 32'h00, 1, 1);
    tbl[2]  = mk(1, 32'h08, 1, 1, 32'h00, 2, 1);
    tbl[3]  = mk(1, 32'h0C, 1, 1, 32'h00, 3, 1);
    tbl[4]  = mk(1, 32'h10, 1, 1, 32'h00, 4, 0);
    tbl[5]  = mk(1, 32'h14, 1, 1, 32'h00, 4, 0);
    tbl[6]  = mk(1, 32'h14, 0, 1, 32'h04, 3, 1);
    tbl[7]  = mk(1, 32'h14, 0, 1, 32'h08, 3, 1);
    tbl[8]  = mk(0, 32'h00, 0, 1, 32'h0C, 2, 1);
    tbl[9]  = mk(0, 32'h00, 0, 1, 32'h10, 1, 1);
    tbl[10] = mk(0, 32'h00, 0, 1, 32'h14, 0, 1);
    tbl[11] = mk(0, 32'h00, 0, 0, 32'h00, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(0, tbl[i].v, tbl[i].pc, 0, tbl[i].st, acc);
      chk("tbl_id_valid", 64'(id_valid), 64'(tbl[i].exp_v));
      chk("tbl_id_pc", 64'(id_pc), 64'(tbl[i].exp_pc));
      chk("tbl_count", 64'(count), 64'(tbl[i].exp_cnt));
      chk("tbl_ready", 64'(if_ready), 64'(tbl[i].exp_rdy));
    end

    // Steady push+pop at count 2 long enough for both pointers to wrap.
    cyc(0, 1, 32'h200, 0, 1, acc);
    cyc(0, 1, 32'h204, 0, 1, acc);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(0, 1, 32'(32'h208 + i * 4), 0, 0, acc);
      chk("pp_count", 64'(count), 64'd2);
      chk("pp_pc", 64'(id_pc), 64'(32'h200 + i * 4));
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 0, acc);

    // Flush while stalled with three buffered entries.
    cyc(0, 1, 32'h300, 0, 1, acc);
    cyc(0, 1, 32'h304, 0, 1, acc);
    cyc(0, 1, 32'h308, 0, 1, acc);
    chk("pre_flush_count", 64'(count), 64'd3);
    cyc(0, 1, 32'h30C, 1, 1, acc);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_id_valid", 64'(id_valid), 64'd0);
    chk("flush_id_pc", 64'(id_pc), 64'd0);
    chk("flush_ready", 64'(if_ready), 64'd1);
    cyc(0, 1, 32'h310, 0, 0, acc);
    chk("post_flush_pc", 64'(id_pc), 64'h310);

    // Stall with no backlog: output register holds.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'h0, 0, 1, acc);
      chk("stall_hold_pc", 64'(id_pc), 64'h310);
      chk("stall_hold_count", 64'(count), 64'd0);
    end

    // Reset arriving mid-drain discards the remaining entries.
    cyc(0, 1, 32'h400, 0, 1, acc);
    cyc(0, 1, 32'h404, 0, 1, acc);
    cyc(0, 1, 32'h408, 0, 1, acc);
    cyc(0, 0, 32'h0, 0, 0, acc);
    cyc(1, 0, 32'h0, 0, 0, acc);
    chk("middrain_rst_count", 64'(count), 64'd0);
    cyc(0, 0, 32'h0, 0, 0, acc);

    // Random traffic; IF holds its pc until accepted, dropped, or reset.
    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 99) == 0);
      cyc(rr, rv, rpc, rb, rs, acc);
      if (acc || (rv && (rb || rr))) rpc = rpc + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
